// File: rtl/prach_fft_pkg.sv
// Shared types and arithmetic helpers for the PRACH radix-2 butterfly stage.
// Pure combinational helpers, no latency, no flow control.
package prach_fft_pkg;

   localparam int TAG_W = 2;
   localparam int SAT_W = 40;

   typedef enum logic [TAG_W-1:0] {
      EMPTY = 2'd0,
      X0    = 2'd1,
      DIFF  = 2'd2
   } tag_e;

   function automatic bit nfft_legal(input int n);
      return (n >= 4) && ((n & (n - 1)) == 0);
   endfunction

   // Optional /2 with round-half-up, then clamp to dw signed bits; returns {clamped, value}.
   function automatic logic [SAT_W:0] sat_round(input logic signed [SAT_W-1:0] v,
                                                input logic scale, input int dw);
      logic signed [SAT_W-1:0] r;
      logic signed [SAT_W-1:0] lim_hi;
      logic signed [SAT_W-1:0] lim_lo;
      logic                    ov;
      lim_hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
      lim_lo = -(SAT_W'(1) <<< (dw - 1));
      r      = scale ? ((v + SAT_W'(1)) >>> 1) : v;
      ov     = 1'b0;
      if (r > lim_hi) begin
         r  = lim_hi;
         ov = 1'b1;
      end else if (r < lim_lo) begin
         r  = lim_lo;
         ov = 1'b1;
      end
      return {ov, r};
   endfunction

endpackage

// File: rtl/prach_fft_bf2_stage_if.sv
// Sample-stream bundle between a PRACH FFT stage and its neighbours.
// Master drives input samples and control, slave returns results and status.
interface prach_fft_bf2_stage_if #(
   parameter int DW = 18
);
   logic signed [DW-1:0] din_dr;
   logic signed [DW-1:0] din_di;
   logic                 din_dv;
   logic                 sync_in;
   logic                 scale_en;
   logic                 ovf_clr;
   logic signed [DW-1:0] dout_dr;
   logic signed [DW-1:0] dout_di;
   logic                 dout_dv;
   logic                 sync_out;
   logic                 ovf;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output din_dr, din_di, din_dv, sync_in, scale_en, ovf_clr,
      input  dout_dr, dout_di, dout_dv, sync_out, ovf, frame_err, busy
   );

   modport slave (
      input  din_dr, din_di, din_dv, sync_in, scale_en, ovf_clr,
      output dout_dr, dout_di, dout_dv, sync_out, ovf, frame_err, busy
   );
endinterface

// File: rtl/prach_delay_en.sv
// Enable-gated shift register of DELAY entries; tail visible combinationally.
// Advances one entry per enabled clock; only the low TAG_WIDTH bits are reset.
module prach_delay_en #(
   parameter int WIDTH     = 38,
   parameter int DELAY     = 32,
   parameter int TAG_WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);
   logic [TAG_WIDTH-1:0]     tag_q [DELAY];
   logic [WIDTH-1:TAG_WIDTH] dat_q [DELAY];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DELAY; i++) begin
            tag_q[i] <= '0;
         end
      end else if (en_i) begin
         tag_q[0] <= din_i[TAG_WIDTH-1:0];
         for (int i = 1; i < DELAY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Payload carries no reset: the tag alone decides whether an entry is meaningful.
   always_ff @(posedge clk) begin
      if (en_i) begin
         dat_q[0] <= din_i[WIDTH-1:TAG_WIDTH];
         for (int i = 1; i < DELAY; i++) begin
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign dout_o = {dat_q[DELAY-1], tag_q[DELAY-1]};

endmodule

// File: rtl/prach_fft_bf2_stage.sv
// Radix-2 DIT butterfly over an N/2 tagged delay line: sums 1 clk after x1, differences drained later.
// No backpressure: accepts any din_dv pattern, self-drains queued differences while idle.
module prach_fft_bf2_stage
   import prach_fft_pkg::*;
#(
   parameter int DATA_WIDTH     = 18,
   parameter int NUM_FFT_LENGTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   prach_fft_bf2_stage_if.slave io
);
   localparam int DW   = DATA_WIDTH;
   localparam int N    = NUM_FFT_LENGTH;
   localparam int HALF = N / 2;
   localparam int CW   = $clog2(N);
   localparam int PW   = $clog2(HALF + 1);
   localparam int EW   = 2 * DW + TAG_W;

   if (!nfft_legal(N)) begin : g_bad_len
      $error("NUM_FFT_LENGTH must be a power of 2 and at least 4");
   end
   if ((DW < 2) || (DW + 2 > SAT_W)) begin : g_bad_dw
      $error("DATA_WIDTH out of supported range");
   end

   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        pend_q, pend_d;
   logic                 scale_q, scale_d;
   logic                 ovf_q, ovf_d;
   logic                 frame_err_q, frame_err_d;
   logic                 sync_out_q, sync_out_d;
   logic                 dout_dv_q, dout_dv_d;
   logic signed [DW-1:0] dout_dr_q, dout_dr_d;
   logic signed [DW-1:0] dout_di_q, dout_di_d;

   logic                 sync_acc;
   logic                 second;
   logic                 shift_en;
   logic                 pop_diff;
   logic [EW-1:0]        head_w;
   logic [EW-1:0]        tail_w;
   tag_e                 tail_tag;
   logic signed [DW-1:0] tail_re, tail_im;

   logic signed [SAT_W-1:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;
   logic [SAT_W:0]          sum_re_s, sum_im_s, dif_re_s, dif_im_s;
   logic signed [DW-1:0]    sum_re, sum_im, dif_re, dif_im;
   logic                    sat_hit;
   logic                    unused_sat_hi;

   prach_delay_en #(
      .WIDTH     (EW),
      .DELAY     (HALF),
      .TAG_WIDTH (TAG_W)
   ) u_line (
      .clk    (clk),
      .rst    (rst),
      .en_i   (shift_en),
      .din_i  (head_w),
      .dout_o (tail_w)
   );

   assign tail_tag = tag_e'(tail_w[TAG_W-1:0]);
   assign tail_re  = tail_w[EW-1 -: DW];
   assign tail_im  = tail_w[TAG_W +: DW];

   // In the second half the tail holds x0[k] paired with the incoming x1[k].
   assign sum_re_w = SAT_W'(tail_re) + SAT_W'(io.din_dr);
   assign sum_im_w = SAT_W'(tail_im) + SAT_W'(io.din_di);
   assign dif_re_w = SAT_W'(tail_re) - SAT_W'(io.din_dr);
   assign dif_im_w = SAT_W'(tail_im) - SAT_W'(io.din_di);

   assign sum_re_s = sat_round(sum_re_w, scale_q, DW);
   assign sum_im_s = sat_round(sum_im_w, scale_q, DW);
   assign dif_re_s = sat_round(dif_re_w, scale_q, DW);
   assign dif_im_s = sat_round(dif_im_w, scale_q, DW);

   assign sum_re  = sum_re_s[DW-1:0];
   assign sum_im  = sum_im_s[DW-1:0];
   assign dif_re  = dif_re_s[DW-1:0];
   assign dif_im  = dif_im_s[DW-1:0];
   assign sat_hit = sum_re_s[SAT_W] | sum_im_s[SAT_W] | dif_re_s[SAT_W] | dif_im_s[SAT_W];

   assign unused_sat_hi = ^{sum_re_s[SAT_W-1:DW], sum_im_s[SAT_W-1:DW],
                            dif_re_s[SAT_W-1:DW], dif_im_s[SAT_W-1:DW]};

   always_comb begin
      sync_acc = io.sync_in & io.din_dv;
      second   = io.din_dv & ~sync_acc & (cnt_q >= CW'(HALF));
      shift_en = io.din_dv | ((cnt_q == '0) & (pend_q != '0));
      pop_diff = shift_en & (tail_tag == DIFF);

      head_w = {{(2 * DW){1'b0}}, EMPTY};
      if (second) begin
         head_w = {dif_re, dif_im, DIFF};
      end else if (io.din_dv) begin
         head_w = {io.din_dr, io.din_di, X0};
      end

      cnt_d = cnt_q;
      if (sync_acc) begin
         cnt_d = CW'(1);
      end else if (io.din_dv) begin
         cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
      end

      pend_d      = pend_q + PW'(second) - PW'(pop_diff);
      scale_d     = sync_acc ? io.scale_en : scale_q;
      ovf_d       = (second & sat_hit) | (ovf_q & ~io.ovf_clr);
      frame_err_d = sync_acc & (cnt_q != '0);
      sync_out_d  = second & (cnt_q == CW'(HALF));

      // Stale X0 entries at the tail (from an aborted frame) fall out without emitting.
      dout_dv_d = second | pop_diff;
      dout_dr_d = dout_dr_q;
      dout_di_d = dout_di_q;
      if (second) begin
         dout_dr_d = sum_re;
         dout_di_d = sum_im;
      end else if (pop_diff) begin
         dout_dr_d = tail_re;
         dout_di_d = tail_im;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         pend_q      <= '0;
         scale_q     <= 1'b0;
         ovf_q       <= 1'b0;
         frame_err_q <= 1'b0;
         sync_out_q  <= 1'b0;
         dout_dv_q   <= 1'b0;
         dout_dr_q   <= '0;
         dout_di_q   <= '0;
      end else begin
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         scale_q     <= scale_d;
         ovf_q       <= ovf_d;
         frame_err_q <= frame_err_d;
         sync_out_q  <= sync_out_d;
         dout_dv_q   <= dout_dv_d;
         dout_dr_q   <= dout_dr_d;
         dout_di_q   <= dout_di_d;
      end
   end

   assign io.dout_dr   = dout_dr_q;
   assign io.dout_di   = dout_di_q;
   assign io.dout_dv   = dout_dv_q;
   assign io.sync_out  = sync_out_q;
   assign io.ovf       = ovf_q;
   assign io.frame_err = frame_err_q;
   assign io.busy      = (cnt_q != '0) | (pend_q != '0);

endmodule
